// File: rtl/ship_motion_ctrl.sv
// rtl/ship_motion_ctrl.sv - tilt-driven ship motion with dead-zone, velocity ramp, edge clamp and hit/respawn lifecycle
module ship_motion_ctrl #(
    parameter int                 CORDW     = 16,
    parameter int                 X_MAX     = 606,
    parameter int                 Y_MAX     = 444,
    parameter int                 X_HOME    = 50,
    parameter int                 Y_HOME    = 240,
    parameter logic signed [15:0] DEAD      = 16'sd1024,
    parameter int                 VMAX      = 8,
    parameter int                 HIT_TICKS = 32,
    parameter int                 LIVES     = 3
) (
    input  logic             slowclk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [15:0]      data_x,
    input  logic [15:0]      data_y,
    input  logic             collision_in,
    output logic [CORDW-1:0] ship_x,
    output logic [CORDW-1:0] ship_y,
    output logic [2:0]       lives,
    output logic             hit_pulse,
    output logic             game_over,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {MOVE = 2'd0, HIT = 2'd1, RESPAWN = 2'd2, OVER = 2'd3} state_t;

    localparam int CW = $clog2(HIT_TICKS + 1);
    localparam logic signed [7:0] VMAX_P = 8'(VMAX);
    localparam logic signed [7:0] VMAX_N = -8'(VMAX);

    state_t            st;
    logic signed [7:0] vx, vy;
    logic [CW-1:0]     hit_cnt;
    logic [1:0]        sync_q;
    logic              coll_prev;
    logic              coll_rise;
    logic [CORDW-1:0]  x_next, y_next;
    logic signed [7:0] vx_next, vy_next;

    assign state     = st;
    assign coll_rise = sync_q[1] & ~coll_prev;

    // The position step uses the freshly updated velocity; hitting either edge kills that axis' velocity.
    function automatic void axis_next(input logic [CORDW-1:0] pos, input logic signed [7:0] v,
                                      input logic [15:0] tilt, input logic [CORDW-1:0] pmax,
                                      output logic [CORDW-1:0] pos_n, output logic signed [7:0] v_n);
        logic [CORDW:0] sum;
        if ($signed(tilt) > DEAD)
            v_n = (v >= VMAX_P) ? VMAX_P : v + 8'sd1;
        else if ($signed(tilt) < -DEAD)
            v_n = (v <= VMAX_N) ? VMAX_N : v - 8'sd1;
        else if (v > 8'sd0)
            v_n = v - 8'sd1;
        else if (v < 8'sd0)
            v_n = v + 8'sd1;
        else
            v_n = v;
        sum = {1'b0, pos} + {{(CORDW-7){v_n[7]}}, v_n};
        if (sum[CORDW]) begin
            pos_n = '0;
            v_n   = 8'sd0;
        end else if (sum[CORDW-1:0] > pmax) begin
            pos_n = pmax;
            v_n   = 8'sd0;
        end else begin
            pos_n = sum[CORDW-1:0];
        end
    endfunction

    always_comb begin
        x_next  = ship_x;
        y_next  = ship_y;
        vx_next = vx;
        vy_next = vy;
        axis_next(ship_x, vx, data_x, CORDW'(X_MAX), x_next, vx_next);
        axis_next(ship_y, vy, data_y, CORDW'(Y_MAX), y_next, vy_next);
    end

    always_ff @(posedge slowclk) begin
        if (!reset_n) begin
            st        <= MOVE;
            ship_x    <= CORDW'(X_HOME);
            ship_y    <= CORDW'(Y_HOME);
            vx        <= 8'sd0;
            vy        <= 8'sd0;
            lives     <= 3'(LIVES);
            hit_cnt   <= '0;
            hit_pulse <= 1'b0;
            game_over <= 1'b0;
            sync_q    <= 2'b00;
            coll_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], collision_in};
            hit_pulse <= 1'b0;
            if (en) begin
                coll_prev <= sync_q[1];
                case (st)
                    MOVE: begin
                        if (coll_rise) begin
                            vx        <= 8'sd0;
                            vy        <= 8'sd0;
                            hit_pulse <= 1'b1;
                            hit_cnt   <= '0;
                            if (lives <= 3'd1) begin
                                lives     <= 3'd0;
                                st        <= OVER;
                                game_over <= 1'b1;
                            end else begin
                                lives <= lives - 3'd1;
                                st    <= HIT;
                            end
                        end else begin
                            ship_x <= x_next;
                            ship_y <= y_next;
                            vx     <= vx_next;
                            vy     <= vy_next;
                        end
                    end
                    HIT: begin
                        if (hit_cnt == CW'(HIT_TICKS - 1))
                            st <= RESPAWN;
                        else
                            hit_cnt <= hit_cnt + 1'b1;
                    end
                    RESPAWN: begin
                        ship_x <= CORDW'(X_HOME);
                        ship_y <= CORDW'(Y_HOME);
                        vx     <= 8'sd0;
                        vy     <= 8'sd0;
                        st     <= MOVE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ship_motion_ctrl.sv
// tb/tb_ship_motion_ctrl.sv - directed table and sequence bench for ship_motion_ctrl
module tb_ship_motion_ctrl;
    logic        slowclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] data_x = 16'h0000;
    logic [15:0] data_y = 16'h0000;
    logic        collision_in = 1'b0;
    logic [15:0] ship_x, ship_y;
    logic [2:0]  lives;
    logic        hit_pulse, game_over;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic [15:0] dx;
        logic [15:0] dy;
        int          reps;
        logic [15:0] ex;
        logic [15:0] ey;
    } vec_t;
    vec_t tbl[$];

    ship_motion_ctrl dut (
        .slowclk(slowclk), .reset_n(reset_n), .en(en), .data_x(data_x), .data_y(data_y),
        .collision_in(collision_in), .ship_x(ship_x), .ship_y(ship_y), .lives(lives),
        .hit_pulse(hit_pulse), .game_over(game_over), .state(state)
    );

    always #5 slowclk = ~slowclk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge slowclk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int ex, input int ey, input int el,
                             input int est, input int ehp, input int ego);
        check({tag, " ship_x"}, 32'(ship_x), 32'(ex));
        check({tag, " ship_y"}, 32'(ship_y), 32'(ey));
        check({tag, " lives"}, 32'(lives), 32'(el));
        check({tag, " state"}, 32'(state), 32'(est));
        check({tag, " hit_pulse"}, 32'(hit_pulse), 32'(ehp));
        check({tag, " game_over"}, 32'(game_over), 32'(ego));
    endtask

    task automatic add(input logic e, input logic [15:0] dx, input logic [15:0] dy, input int reps,
                       input logic [15:0] ex, input logic [15:0] ey);
        vec_t v;
        v.en = e; v.dx = dx; v.dy = dy; v.reps = reps; v.ex = ex; v.ey = ey;
        tbl.push_back(v);
    endtask

    initial begin
        add(1, 16'h4000, 16'h0000, 10, 102, 240);
        add(1, 16'h4000, 16'h0000, 63, 606, 240);
        add(1, 16'h4000, 16'h0000, 1, 606, 240);
        add(1, 16'h4000, 16'h0000, 1, 606, 240);
        add(1, 16'hC000, 16'h0000, 1, 605, 240);
        add(1, 16'hC000, 16'h0000, 1, 603, 240);
        add(1, 16'hC000, 16'h0000, 200, 0, 240);
        add(1, 16'h4000, 16'h0000, 3, 6, 240);
        add(1, 16'h0400, 16'h0000, 1, 8, 240);
        add(1, 16'h0400, 16'h0000, 1, 9, 240);
        add(1, 16'h0400, 16'h0000, 1, 9, 240);
        add(1, 16'hFC00, 16'h0000, 1, 9, 240);
        add(1, 16'h0401, 16'h0000, 1, 10, 240);
        add(1, 16'hFBFF, 16'h0000, 1, 10, 240);
        add(1, 16'hFBFF, 16'h0000, 1, 9, 240);
        add(1, 16'h0000, 16'h4000, 2, 9, 243);
        add(0, 16'h0000, 16'h4000, 5, 9, 243);
        add(1, 16'h0000, 16'h0000, 1, 9, 244);
        add(1, 16'h0000, 16'h0000, 1, 9, 244);
        add(1, 16'h0000, 16'hC000, 1, 9, 243);
        add(1, 16'h0000, 16'h0000, 1, 9, 243);

        tick(2);
        check_all("reset", 50, 240, 3, 0, 0, 0);
        reset_n = 1'b1;

        foreach (tbl[k]) begin
            en = tbl[k].en; data_x = tbl[k].dx; data_y = tbl[k].dy;
            tick(tbl[k].reps);
            check($sformatf("vec%0d ship_x", k), 32'(ship_x), 32'(tbl[k].ex));
            check($sformatf("vec%0d ship_y", k), 32'(ship_y), 32'(tbl[k].ey));
            check($sformatf("vec%0d state", k), 32'(state), 32'd0);
        end

        // First hit: three-cycle latency, en gap inside HIT, held collision counts once
        en = 1'b1; data_x = 16'h0000; data_y = 16'h0000;
        collision_in = 1'b1;
        tick(1);
        check("c1 t1 hit_pulse", 32'(hit_pulse), 0);
        tick(1);
        check("c1 t2 hit_pulse", 32'(hit_pulse), 0);
        tick(1);
        check_all("c1 t3", 9, 243, 2, 1, 1, 0);
        tick(1);
        check("c1 pulse width", 32'(hit_pulse), 0);
        tick(15);
        en = 1'b0;
        tick(5);
        check("c1 en hold state", 32'(state), 1);
        en = 1'b1;
        data_x = 16'h4000;
        tick(15);
        check_all("c1 hit end", 9, 243, 2, 1, 0, 0);
        tick(1);
        check_all("c1 respawn", 9, 243, 2, 2, 0, 0);
        data_x = 16'h0000;
        tick(1);
        check_all("c1 move", 50, 240, 2, 0, 0, 0);
        tick(2);
        check_all("c1 held high", 50, 240, 2, 0, 0, 0);
        collision_in = 1'b0;
        tick(3);

        // Rise while en=0 is delivered on the first en tick; then reset mid-HIT
        collision_in = 1'b1;
        en = 1'b0;
        tick(5);
        check("c2 en0 hit_pulse", 32'(hit_pulse), 0);
        check("c2 en0 state", 32'(state), 0);
        en = 1'b1;
        tick(1);
        check_all("c2 hit", 50, 240, 1, 1, 1, 0);
        collision_in = 1'b0;
        tick(10);
        reset_n = 1'b0;
        tick(1);
        check_all("c2 reset", 50, 240, 3, 0, 0, 0);
        reset_n = 1'b1;
        tick(3);

        for (int k = 0; k < 3; k++) begin
            collision_in = 1'b1;
            tick(3);
            check_all($sformatf("go%0d hit", k), 50, 240, 2 - k, (k == 2) ? 3 : 1, 1, (k == 2) ? 1 : 0);
            collision_in = 1'b0;
            if (k < 2) begin
                tick(33);
                check($sformatf("go%0d back", k), 32'(state), 0);
            end
        end
        data_x = 16'h4000;
        collision_in = 1'b1;
        tick(5);
        check_all("game over frozen", 50, 240, 0, 3, 0, 1);
        collision_in = 1'b0;
        reset_n = 1'b0;
        tick(1);
        check_all("final reset", 50, 240, 3, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
